sc_poly_sequencer: RTL
======================

Name: sc_poly_sequencer

Overview:
Sequencer for the combinational 3-input stochastic Bernstein polynomial evaluator.
- On start, latches an 8-bit operand and runs a fixed-length stochastic evaluation. Each cycle it generates three decorrelated x bitstreams and six fair random r bits with LFSRs.
- Drives these to the evaluator, counts the 1s on the returned z stream, and reports the count as the binary result.
- Sits between a host-side register interface and the polynomial block.

Parameters:
LEN, 255, stream length in cycles; legal range 1..65535.
SEED_X0, 8'h01, reset/reload seed of x LFSR 0; must be nonzero.
SEED_X1, 8'h5A, reset/reload seed of x LFSR 1; must be nonzero.
SEED_X2, 8'hC3, reset/reload seed of x LFSR 2; must be nonzero.
SEED_R, 16'hACE1, reset/reload seed of r LFSR; must be nonzero.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request evaluation; accepted only in IDLE
abort  input  1  synchronous cancel; returns to IDLE, no done
x_val  input  8  operand; latched when start is accepted
busy  output  1  high in RUN, DRAIN and DONE
poly_x  output  3  registered x bitstreams to evaluator
poly_r  output  6  registered random bits to evaluator
poly_z  input  1  evaluator output, combinational from poly_x/poly_r
result  output  16  count of 1s on poly_z over the last completed run
done  output  1  one-cycle pulse when result updates

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - busy=0, done=0, result=0, poly_x=0, poly_r=0.
  - LFSRs are loaded with their seeds; sample counter=0; ones counter=0.
- x LFSRs: three 8-bit Fibonacci LFSRs, polynomial x^8+x^6+x^5+x^4+1, maximal period 255.
- r LFSR: 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
- LFSRs advance only in RUN, one step per cycle.
- Stream generation, per RUN cycle:
  - poly_x[i] is registered from (lfsrXi <= x_lat), an unsigned compare. Since lfsr ranges 1..255, x_lat=0 gives constant 0 and x_lat=255 gives constant 1.
  - With LEN=255, each x stream contains exactly x_lat ones.
  - poly_r is registered from r-LFSR bits {15,12,9,6,3,0}, mapping to poly_r[5..0].
- FSM:
  - IDLE: start=1 latches x_val into x_lat, reloads all LFSRs from their seeds, clears the ones counter and sample counter, and moves to RUN.
  - RUN: drives one sample per cycle. The sample counter counts 1..LEN. After the LEN-th sample is driven, moves to DRAIN.
  - DRAIN: one cycle. Captures poly_z for the last sample. poly_x/poly_r return to 0.
  - DONE: one cycle. result <= ones count, done=1, then moves to IDLE.
- Capture timing: poly_z is sampled the cycle after its poly_x/poly_r values are registered. Exactly LEN samples are counted: the first in the first RUN+1 cycle, the last in DRAIN.
- Latency: start is accepted on edge E0, and done is high in the cycle after edge E0+LEN+2. busy is high for LEN+2 cycles.
- start while busy is ignored and not queued. start and abort in the same IDLE cycle: abort wins and nothing starts.
- abort in RUN or DRAIN returns to IDLE on the next edge. result is unchanged, no done pulse, poly_x/poly_r are driven to 0.
- abort in DONE has no effect: the result still commits.
- Ones counter is 16 bits and cannot overflow because LEN<=65535.
- result holds its value until the next done.
- x_val changes during RUN have no effect.
- Reset mid-run behaves as full reset: result=0.

Test Plan:
- Reset then idle; no start for 10 cycles -> busy=0, done=0, result=0, poly_x=0, poly_r=0.
- LEN=255, x_val=8'd100, bench ties poly_z=poly_x[0] -> done exactly 257 cycles after the start edge; result=100. Repeat with poly_x[1] and poly_x[2] -> result=100 each.
- LEN=255, x_val=0 then x_val=255, poly_z=poly_x[2] -> result=0, then 255; poly_x stays 3'b000 / 3'b111 for the whole run.
- Real evaluator attached, x_val=128, two back-to-back runs -> identical result both runs (seed reload makes runs deterministic); each poly_r bit count is within 128±20 over 255 cycles.
- start pulsed 5 times during RUN, then abort at sample 50 -> no extra runs, no done; result keeps the prior value; busy=0 on the next cycle.
- rst_n low for 1 cycle mid-RUN, asynchronous to clk -> outputs are 0 immediately; a fresh start afterwards reproduces the reference result from the x_val=100 scenario.

Source files
------------

// File: rtl/sc_poly_sequencer.sv
// sc_poly_sequencer: drives LFSR-derived stochastic streams into a Bernstein polynomial evaluator
// and counts the ones on the returned z stream.
module sc_poly_sequencer #(
  parameter int         LEN     = 255,
  parameter logic [7:0] SEED_X0 = 8'h01,
  parameter logic [7:0] SEED_X1 = 8'h5A,
  parameter logic [7:0] SEED_X2 = 8'hC3,
  parameter logic [15:0] SEED_R = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  x_val,
  output logic        busy,
  output logic [2:0]  poly_x,
  output logic [5:0]  poly_r,
  input  logic        poly_z,
  output logic [15:0] result,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [15:0] LAST = 16'(LEN - 1);
  state_t state_q, state_d;
  logic [7:0]  x_lat_q, lx0_q, lx1_q, lx2_q;
  logic [15:0] lr_q, cnt_q, ones_q, result_q;
  logic [2:0]  px_q;
  logic [5:0]  pr_q;
  logic        done_q, load, step, capture;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = (start && !abort) ? RUN : IDLE;
      RUN:     state_d = abort ? IDLE : (cnt_q == LAST) ? DRAIN : RUN;
      DRAIN:   state_d = abort ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign load    = (state_q == IDLE) && (state_d == RUN);
  assign step    = (state_q == RUN) && !abort;
  // z reflects the sample registered on the previous edge, so capture lags drive by one cycle
  assign capture = ((state_q == RUN) && (cnt_q != 16'd0)) || (state_q == DRAIN);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_lat_q  <= 8'd0;
      lx0_q    <= SEED_X0;
      lx1_q    <= SEED_X1;
      lx2_q    <= SEED_X2;
      lr_q     <= SEED_R;
      cnt_q    <= 16'd0;
      ones_q   <= 16'd0;
      result_q <= 16'd0;
      px_q     <= 3'd0;
      pr_q     <= 6'd0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DONE);
      if (state_q == DONE) result_q <= ones_q;
      if (capture) ones_q <= ones_q + {15'd0, poly_z};
      if (load) begin
        x_lat_q <= x_val;
        lx0_q   <= SEED_X0;
        lx1_q   <= SEED_X1;
        lx2_q   <= SEED_X2;
        lr_q    <= SEED_R;
        cnt_q   <= 16'd0;
        ones_q  <= 16'd0;
      end
      if (step) begin
        px_q  <= {lx2_q <= x_lat_q, lx1_q <= x_lat_q, lx0_q <= x_lat_q};
        pr_q  <= {lr_q[15], lr_q[12], lr_q[9], lr_q[6], lr_q[3], lr_q[0]};
        lx0_q <= {lx0_q[6:0], lx0_q[7] ^ lx0_q[5] ^ lx0_q[4] ^ lx0_q[3]};
        lx1_q <= {lx1_q[6:0], lx1_q[7] ^ lx1_q[5] ^ lx1_q[4] ^ lx1_q[3]};
        lx2_q <= {lx2_q[6:0], lx2_q[7] ^ lx2_q[5] ^ lx2_q[4] ^ lx2_q[3]};
        lr_q  <= {lr_q[14:0], lr_q[15] ^ lr_q[13] ^ lr_q[12] ^ lr_q[10]};
        cnt_q <= cnt_q + 16'd1;
      end else begin
        px_q <= 3'd0;
        pr_q <= 6'd0;
      end
    end
  end
  assign busy   = (state_q != IDLE);
  assign poly_x = px_q;
  assign poly_r = pr_q;
  assign result = result_q;
  assign done   = done_q;
endmodule
